// File: rtl/vga_fb_write_ctrl.sv
// vga_fb_write_ctrl
//   Write-side controller for the 640x480 RGB444 framebuffer port. It shares
//   the single write port between CPU pixel writes (valid/ready) and an
//   internal rectangle-fill engine. Grants are round-robin under contention,
//   and at most one framebuffer write is issued per clock.
//
// Ports
//   clk, rst                      pixel clock, async active-high reset
//   cpu_valid/cpu_ready           CPU pixel write handshake
//   cpu_x, cpu_y, cpu_color       CPU pixel coordinates and colour
//   fill_start                    pulse; latches fill_x0/y0/w/h/color
//   fill_busy, fill_done          engine drawing / one-cycle completion
//   coord_err                     accepted CPU write was off-screen
//   fb_we, fb_addr, fb_data       registered framebuffer write port
module vga_fb_write_ctrl #(
  parameter int H_VISIBLE = 640,
  parameter int V_VISIBLE = 480,
  parameter int ADDR_W    = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_valid,
  output logic              cpu_ready,
  input  logic [9:0]        cpu_x,
  input  logic [9:0]        cpu_y,
  input  logic [11:0]       cpu_color,
  input  logic              fill_start,
  input  logic [9:0]        fill_x0,
  input  logic [9:0]        fill_y0,
  input  logic [9:0]        fill_w,
  input  logic [9:0]        fill_h,
  input  logic [11:0]       fill_color,
  output logic              fill_busy,
  output logic              fill_done,
  output logic              coord_err,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [11:0]       fb_data
);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
  state_t state, state_nxt;

  localparam logic [10:0]       H_LIM  = 11'(H_VISIBLE);
  localparam logic [10:0]       V_LIM  = 11'(V_VISIBLE);
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(H_VISIBLE);

  function automatic logic [ADDR_W-1:0] pix_addr(input logic [9:0] x, input logic [9:0] y);
    return ADDR_W'(y) * STRIDE + ADDR_W'(x);
  endfunction

  // Fill engine context
  logic [9:0]  cx, cy, x0_r;
  logic [10:0] x_end, y_end;
  logic [11:0] fcolor;
  logic        rr_last;   // 1: fill was granted last, 0: CPU was granted last

  // 11-bit sums so a rectangle hanging off the screen edge clips instead of wrapping
  logic [10:0] x_sum, y_sum;
  logic        fill_empty, fill_req, cpu_grant, fill_grant, cpu_in_range;
  logic        row_end, last_pix;

  assign x_sum      = {1'b0, fill_x0} + {1'b0, fill_w};
  assign y_sum      = {1'b0, fill_y0} + {1'b0, fill_h};
  assign fill_empty = (fill_w == 10'd0) || (fill_h == 10'd0) ||
                      ({1'b0, fill_x0} >= H_LIM) || ({1'b0, fill_y0} >= V_LIM);

  // Round-robin: with the engine requesting, the CPU only wins if the fill
  // had the previous grant. Ready is independent of cpu_valid.
  assign fill_req     = (state == FILL);
  assign cpu_ready    = !fill_req || rr_last;
  assign cpu_grant    = cpu_valid && cpu_ready;
  assign fill_grant   = fill_req && !cpu_grant;
  assign cpu_in_range = ({1'b0, cpu_x} < H_LIM) && ({1'b0, cpu_y} < V_LIM);

  assign row_end  = ({1'b0, cx} == x_end - 11'd1);
  assign last_pix = row_end && ({1'b0, cy} == y_end - 11'd1);

  assign fill_busy = (state == FILL);
  assign fill_done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fill_start) state_nxt = fill_empty ? DONE : FILL;
      FILL:    if (fill_grant && last_pix) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cx      <= '0;
      cy      <= '0;
      x0_r    <= '0;
      x_end   <= '0;
      y_end   <= '0;
      fcolor  <= '0;
      rr_last <= 1'b1;   // CPU wins the first contention
    end else begin
      if (state == IDLE && fill_start) begin
        cx     <= fill_x0;
        cy     <= fill_y0;
        x0_r   <= fill_x0;
        fcolor <= fill_color;
        x_end  <= (x_sum > H_LIM) ? H_LIM : x_sum;
        y_end  <= (y_sum > V_LIM) ? V_LIM : y_sum;
      end
      if (fill_grant) begin
        if (row_end) begin
          cx <= x0_r;
          cy <= cy + 10'd1;
        end else begin
          cx <= cx + 10'd1;
        end
      end
      // An off-screen CPU write still consumes its grant
      if (cpu_grant)       rr_last <= 1'b0;
      else if (fill_grant) rr_last <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fb_we     <= 1'b0;
      fb_addr   <= '0;
      fb_data   <= '0;
      coord_err <= 1'b0;
    end else begin
      fb_we     <= (cpu_grant && cpu_in_range) || fill_grant;
      coord_err <= cpu_grant && !cpu_in_range;
      if (fill_grant) begin
        fb_addr <= pix_addr(cx, cy);
        fb_data <= fcolor;
      end else if (cpu_grant && cpu_in_range) begin
        fb_addr <= pix_addr(cpu_x, cpu_y);
        fb_data <= cpu_color;
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_write_ctrl.sv
// Bench for vga_fb_write_ctrl: CPU write vector table, directed fill
// sequences (clipping, contention, empty fill, ignored restart, reset
// mid-fill) and randomized fills with random CPU traffic against a
// rectangle/queue reference model.
module tb_vga_fb_write_ctrl;
  localparam int H = 640;
  localparam int V = 480;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_valid, cpu_ready;
  logic [9:0]  cpu_x, cpu_y;
  logic [11:0] cpu_color;
  logic        fill_start;
  logic [9:0]  fill_x0, fill_y0, fill_w, fill_h;
  logic [11:0] fill_color;
  logic        fill_busy, fill_done, coord_err, fb_we;
  logic [18:0] fb_addr;
  logic [11:0] fb_data;

  vga_fb_write_ctrl #(.H_VISIBLE(H), .V_VISIBLE(V), .ADDR_W(19)) dut (
    .clk(clk), .rst(rst),
    .cpu_valid(cpu_valid), .cpu_ready(cpu_ready),
    .cpu_x(cpu_x), .cpu_y(cpu_y), .cpu_color(cpu_color),
    .fill_start(fill_start), .fill_x0(fill_x0), .fill_y0(fill_y0),
    .fill_w(fill_w), .fill_h(fill_h), .fill_color(fill_color),
    .fill_busy(fill_busy), .fill_done(fill_done), .coord_err(coord_err),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct { int t; int addr; int data; } wr_t;
  wr_t wr_q[$];
  int  done_q[$];
  int  err_q[$];
  int  exp_q[$];

  // Monitor samples on the falling edge; stimulus moves 1 time unit later.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (fb_we === 1'b1) wr_q.push_back('{cyc, int'(fb_addr), int'(fb_data)});
    if (fill_done === 1'b1) done_q.push_back(cyc);
    if (coord_err === 1'b1) err_q.push_back(cyc);
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear();
    wr_q.delete();
    done_q.delete();
    err_q.delete();
  endtask

  // Reference: every on-screen pixel of the rectangle, row-major.
  task automatic model_fill(input int x0, input int y0, input int w, input int h);
    exp_q.delete();
    if (w > 0 && h > 0 && x0 < H && y0 < V)
      for (int y = y0; y < y0 + h && y < V; y++)
        for (int x = x0; x < x0 + w && x < H; x++)
          exp_q.push_back(y * H + x);
  endtask

  // Runs one fill with optional random CPU traffic (cpu_pct %). CPU colours
  // keep bit 11 clear, fill colours (when CPU traffic is on) keep it set.
  // restart>0 pulses a decoy fill_start that many cycles in.
  task automatic run_fill(input int x0, input int y0, input int w, input int h,
                          input int col, input int cpu_pct, input int restart,
                          input string tag);
    int cpu_a[$], cpu_d[$], fw_a[$], fw_d[$], fw_t[$], cw_a[$], cw_d[$];
    int errs_exp, wt, max_wait, c0, n, px, py, pc, mm, exp_done;
    bit pending, timed_out;
    errs_exp = 0; wt = 0; max_wait = 0; n = 0; px = 0; py = 0; pc = 0; mm = 0;
    pending = 0; timed_out = 1;
    model_fill(x0, y0, w, h);
    clear();
    c0 = cyc;
    fill_x0 = 10'(x0); fill_y0 = 10'(y0); fill_w = 10'(w); fill_h = 10'(h);
    fill_color = 12'(col); fill_start = 1'b1;
    while (n < 3000) begin
      if (!pending && cpu_pct > 0 && $urandom_range(0, 99) < cpu_pct) begin
        pending = 1;
        px = $urandom_range(0, 700);
        py = $urandom_range(0, 520);
        pc = $urandom_range(0, 'h7FF);
      end
      cpu_valid = pending; cpu_x = 10'(px); cpu_y = 10'(py); cpu_color = 12'(pc);
      if (pending) begin
        if (cpu_ready) begin
          if (px < H && py < V) begin cpu_a.push_back(py * H + px); cpu_d.push_back(pc); end
          else errs_exp++;
          pending = 0; wt = 0;
        end else begin
          wt++;
          if (wt > max_wait) max_wait = wt;
        end
      end
      step();
      n++;
      fill_start = 1'b0;
      if (restart > 0 && n == restart) begin
        fill_x0 = 10'd0; fill_y0 = 10'd0; fill_w = 10'd5; fill_h = 10'd5;
        fill_color = 12'h555; fill_start = 1'b1;
      end
      if (done_q.size() > 0 && !pending) begin timed_out = 0; break; end
    end
    cpu_valid = 1'b0; fill_start = 1'b0;
    step(); step();
    foreach (wr_q[i]) begin
      if (cpu_pct == 0 || wr_q[i].data[11]) begin
        fw_a.push_back(wr_q[i].addr); fw_d.push_back(wr_q[i].data); fw_t.push_back(wr_q[i].t);
      end else begin
        cw_a.push_back(wr_q[i].addr); cw_d.push_back(wr_q[i].data);
      end
    end
    check({tag, "_timeout"}, timed_out, 0);
    check({tag, "_fill_count"}, fw_a.size(), exp_q.size());
    for (int i = 0; i < fw_a.size() && i < exp_q.size(); i++)
      if (fw_a[i] != exp_q[i] || fw_d[i] != col) mm++;
    check({tag, "_fill_pixels_bad"}, mm, 0);
    check({tag, "_done_count"}, done_q.size(), 1);
    exp_done = (exp_q.size() == 0 || fw_t.size() == 0) ? c0 + 1 : fw_t[fw_t.size() - 1];
    if (done_q.size() > 0) check({tag, "_done_cycle"}, done_q[0], exp_done);
    check({tag, "_busy_end"}, fill_busy, 0);
    if (cpu_pct == 0 && fw_t.size() > 0) begin
      check({tag, "_first_wr_cycle"}, fw_t[0], c0 + 2);
      check({tag, "_wr_contiguous"}, fw_t[fw_t.size() - 1] - fw_t[0], fw_t.size() - 1);
    end
    if (cpu_pct > 0) begin
      mm = 0;
      for (int i = 0; i < cw_a.size() && i < cpu_a.size(); i++)
        if (cw_a[i] != cpu_a[i] || cw_d[i] != cpu_d[i]) mm++;
      check({tag, "_cpu_count"}, cw_a.size(), cpu_a.size());
      check({tag, "_cpu_writes_bad"}, mm, 0);
      check({tag, "_coord_err_count"}, err_q.size(), errs_exp);
      check({tag, "_cpu_wait_le1"}, max_wait <= 1, 1);
    end
  endtask

  typedef struct { int x; int y; int col; int ready; int we; int addr; int err; } vec_t;
  vec_t vec[7];

  initial begin
    int c0, mm;
    vec[0] = '{10,   2,    'hF0A, 1, 1, 1290,   0};
    vec[1] = '{639,  479,  'hFFF, 1, 1, 307199, 0};
    vec[2] = '{0,    0,    'h123, 1, 1, 0,      0};
    vec[3] = '{640,  0,    'h111, 1, 0, 0,      1};
    vec[4] = '{0,    480,  'h222, 1, 0, 0,      1};
    vec[5] = '{1023, 1023, 'h333, 1, 0, 0,      1};
    vec[6] = '{5,    5,    'hABC, 1, 1, 3205,   0};

    rst = 1'b0; cpu_valid = 1'b0; cpu_x = '0; cpu_y = '0; cpu_color = '0;
    fill_start = 1'b0; fill_x0 = '0; fill_y0 = '0; fill_w = '0; fill_h = '0; fill_color = '0;
    #1 rst = 1'b1;
    #1;
    check("rst_fb_we", fb_we, 0);
    check("rst_fb_addr", fb_addr, 0);
    check("rst_fb_data", fb_data, 0);
    check("rst_fill_busy", fill_busy, 0);
    check("rst_fill_done", fill_done, 0);
    check("rst_coord_err", coord_err, 0);
    check("rst_cpu_ready", cpu_ready, 1);
    step();
    rst = 1'b0;
    step();

    // CPU single writes
    for (int i = 0; i < 7; i++) begin
      clear();
      cpu_valid = 1'b1; cpu_x = 10'(vec[i].x); cpu_y = 10'(vec[i].y); cpu_color = 12'(vec[i].col);
      check($sformatf("cpu%0d_ready", i), cpu_ready, vec[i].ready);
      step();
      cpu_valid = 1'b0;
      check($sformatf("cpu%0d_we_count", i), wr_q.size(), vec[i].we);
      if (vec[i].we == 1 && wr_q.size() > 0) begin
        check($sformatf("cpu%0d_addr", i), wr_q[0].addr, vec[i].addr);
        check($sformatf("cpu%0d_data", i), wr_q[0].data, vec[i].col);
      end
      check($sformatf("cpu%0d_coord_err", i), err_q.size(), vec[i].err);
    end
    clear();
    step();
    check("idle_no_we", wr_q.size(), 0);
    check("idle_no_err", err_q.size(), 0);

    // Clipped corner fill, CPU idle
    run_fill(638, 478, 4, 3, 'h0F0, 0, 0, "corner");
    // Empty fills
    run_fill(20, 20, 0, 5, 'h00F, 0, 0, "empty_w");
    run_fill(700, 20, 4, 4, 'h00F, 0, 0, "empty_x");
    // fill_start while running is ignored
    run_fill(10, 10, 8, 2, 'h8AB, 0, 3, "restart");

    // Contention: CPU held high from the fill_start cycle
    clear();
    c0 = cyc;
    fill_x0 = 10'd0; fill_y0 = 10'd0; fill_w = 10'd4; fill_h = 10'd1; fill_color = 12'h0AA;
    fill_start = 1'b1;
    cpu_valid = 1'b1; cpu_x = 10'd5; cpu_y = 10'd5; cpu_color = 12'h5A5;
    check("cont_ready0", cpu_ready, 1);
    step();
    fill_start = 1'b0;
    repeat (7) step();
    cpu_valid = 1'b0;
    step(); step();
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin exp_q.push_back(3205); exp_q.push_back(i); end
    mm = 0;
    c0 = c0 + 1;
    for (int i = 0; i < 8; i++) begin
      if (i >= wr_q.size()) mm++;
      else if (wr_q[i].t != c0 + i || wr_q[i].addr != exp_q[i] ||
               wr_q[i].data != ((i % 2 == 0) ? 'h5A5 : 'h0AA)) mm++;
    end
    check("cont_sequence_bad", mm, 0);
    check("cont_done_count", done_q.size(), 1);
    if (done_q.size() > 0) check("cont_done_cycle", done_q[0], c0 + 7);

    // Reset in the middle of a large fill
    clear();
    fill_x0 = 10'd0; fill_y0 = 10'd0; fill_w = 10'd100; fill_h = 10'd100; fill_color = 12'h777;
    fill_start = 1'b1;
    step();
    fill_start = 1'b0;
    repeat (50) step();
    check("midfill_busy_before_rst", fill_busy, 1);
    rst = 1'b1;
    #1;
    check("rst_mid_fb_we", fb_we, 0);
    check("rst_mid_fill_busy", fill_busy, 0);
    check("rst_mid_fill_done", fill_done, 0);
    clear();
    repeat (3) step();
    rst = 1'b0;
    repeat (4) step();
    check("rst_mid_no_writes", wr_q.size(), 0);
    check("rst_mid_no_done", done_q.size(), 0);
    run_fill(3, 3, 2, 2, 'h321, 0, 0, "post_rst");

    // Random fills with random CPU traffic
    for (int k = 0; k < 12; k++) begin
      int x0, y0;
      x0 = ($urandom_range(0, 3) == 0) ? 628 + $urandom_range(0, 16) : $urandom_range(0, 660);
      y0 = ($urandom_range(0, 3) == 0) ? 472 + $urandom_range(0, 12) : $urandom_range(0, 490);
      run_fill(x0, y0, $urandom_range(0, 24), $urandom_range(0, 8),
               'h800 | $urandom_range(0, 'h7FF), 50, 0, $sformatf("rnd%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
